// File: rtl/dmem_io_responder.sv
// Memory-mapped I/O page beside dmem: cycle counter, scratch register and a store-to-stream FIFO.
// Define DMEM_IO_IRQ_EN to add the irq output and the STATUS interrupt-enable bit.
module dmem_io_responder #(
   parameter logic [7:0] BASE_PAGE = 8'hFF,
   parameter int         FIFO_AW   = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [11:0] address_dmem,
   input  logic [31:0] data,
   input  logic        wren,
   output logic [31:0] q_io,
   output logic        io_hit,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready
`ifdef DMEM_IO_IRQ_EN
   ,
   output logic        irq
`endif
);

   localparam int                 DEPTH       = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0]   FULL_COUNT  = (FIFO_AW + 1)'(DEPTH);
   localparam logic [FIFO_AW-1:0] PTR_ONE     = 1;
   localparam logic [3:0]         OFF_STATUS  = 4'h0;
   localparam logic [3:0]         OFF_TXDATA  = 4'h1;
   localparam logic [3:0]         OFF_CYCLE   = 4'h2;
   localparam logic [3:0]         OFF_SCRATCH = 4'h3;

   logic [31:0]        r_mem [DEPTH];
   logic [FIFO_AW-1:0] r_wptr;
   logic [FIFO_AW-1:0] r_rptr;
   logic [FIFO_AW:0]   r_count;
   logic               r_ovf;
   logic [31:0]        r_cycle;
   logic [31:0]        r_scratch;
   logic [31:0]        r_q_io;
   logic               r_io_hit;

   logic               w_sel;
   logic [3:0]         w_off;
   logic               w_wr;
   logic               w_empty;
   logic               w_full;
   logic               w_pop;
   logic               w_push_req;
   logic               w_push;
   logic               w_drop;
   logic               w_clr_ovf;
   logic               w_ovf_nxt;
   logic [FIFO_AW:0]   w_count_nxt;
   logic [31:0]        w_cycle_nxt;
   logic [3:0]         w_count4;
   logic [31:0]        w_status;
   logic [31:0]        w_rdata;

`ifdef DMEM_IO_IRQ_EN
   logic               r_ie;
   logic               r_irq;
   logic               w_ie_nxt;
`endif

   always_comb begin
      w_sel      = (address_dmem[11:4] == BASE_PAGE);
      w_off      = address_dmem[3:0];
      w_wr       = w_sel && wren;
      w_empty    = (r_count == '0);
      w_full     = (r_count == FULL_COUNT);
      w_pop      = !w_empty && out_ready;
      w_push_req = w_wr && (w_off == OFF_TXDATA);
      // A full FIFO still accepts a word when the head leaves on the same edge.
      w_push     = w_push_req && (!w_full || w_pop);
      w_drop     = w_push_req && w_full && !w_pop;
      w_clr_ovf  = w_wr && (w_off == OFF_STATUS) && data[8];
      w_ovf_nxt  = w_drop ? 1'b1 : (w_clr_ovf ? 1'b0 : r_ovf);
      w_count_nxt = r_count + {{FIFO_AW{1'b0}}, w_push} - {{FIFO_AW{1'b0}}, w_pop};
      w_cycle_nxt = (w_wr && (w_off == OFF_CYCLE)) ? data : r_cycle + 32'd1;
   end

   always_comb begin
      w_count4    = 4'(r_count);
      w_status    = 32'b0;
      w_status[8] = r_ovf;
      w_status[7:4] = w_count4;
      w_status[1] = w_full;
      w_status[0] = w_empty;
`ifdef DMEM_IO_IRQ_EN
      w_status[9] = r_ie;
`endif
      case (w_off)
         OFF_STATUS:  w_rdata = w_status;
         OFF_CYCLE:   w_rdata = r_cycle;
         OFF_SCRATCH: w_rdata = r_scratch;
         default:     w_rdata = 32'b0;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_q_io    <= 32'b0;
         r_io_hit  <= 1'b0;
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_count   <= '0;
         r_ovf     <= 1'b0;
         r_cycle   <= 32'b0;
         r_scratch <= 32'b0;
      end else begin
         r_io_hit <= w_sel;
         r_q_io   <= w_sel ? w_rdata : 32'b0;
         r_count  <= w_count_nxt;
         r_ovf    <= w_ovf_nxt;
         r_cycle  <= w_cycle_nxt;
         if (w_push)
            r_wptr <= r_wptr + PTR_ONE;
         if (w_pop)
            r_rptr <= r_rptr + PTR_ONE;
         if (w_wr && (w_off == OFF_SCRATCH))
            r_scratch <= data;
      end
   end

   // Storage is not reset; the pointers alone define which entries are live.
   always_ff @(posedge clock) begin
      if (w_push)
         r_mem[r_wptr] <= data;
   end

`ifdef DMEM_IO_IRQ_EN
   always_comb begin
      w_ie_nxt = (w_wr && (w_off == OFF_STATUS)) ? data[9] : r_ie;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_ie  <= 1'b0;
         r_irq <= 1'b0;
      end else begin
         r_ie  <= w_ie_nxt;
         r_irq <= w_ovf_nxt | (w_ie_nxt & (w_count_nxt == '0));
      end
   end

   assign irq = r_irq;
`endif

   assign q_io      = r_q_io;
   assign io_hit    = r_io_hit;
   assign out_data  = r_mem[r_rptr];
   assign out_valid = !w_empty;

endmodule
